// File: rtl/m_dram_bist.sv
// m_dram_bist: DDR3 pattern write/readback self test on the MIG app_* interface.
// Build option DRAM_BIST_STOP_ON_ERR_EN: stop issuing reads at the first mismatch.
module m_dram_bist #(
   parameter int ADDR_WIDTH      = 29,
   parameter int DATA_WIDTH      = 128,
   parameter int MASK_WIDTH      = 16,
   parameter int ADDR_STEP       = 8,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  w_clk,
   input  logic                  w_rst_n,
   input  logic                  w_calib_done,
   input  logic                  w_start,
   input  logic [1:0]            w_mode,
   input  logic [ADDR_WIDTH-1:0] w_base_addr,
   input  logic [ADDR_WIDTH-1:0] w_last_addr,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   output logic [DATA_WIDTH-1:0] app_wdf_data,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   output logic [MASK_WIDTH-1:0] app_wdf_mask,
   input  logic                  app_rdy,
   input  logic                  app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0] app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic                  r_busy,
   output logic                  r_done,
   output logic [31:0]           r_err_cnt,
   output logic [ADDR_WIDTH-1:0] r_first_err_addr,
   output logic [31:0]           r_sum,
   output logic [2:0]            r_state
);

   localparam int LANES = DATA_WIDTH / 32;
   localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
`ifdef DRAM_BIST_STOP_ON_ERR_EN
   localparam logic STOP_EN = 1'b1;
`else
   localparam logic STOP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WWAIT = 3'd2,
      RINIT = 3'd3,
      READ  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmp_q, cmp_d;
   logic [ADDR_WIDTH-1:0] first_q, first_d;
   logic [31:0]           wlfsr_q, wlfsr_d, rlfsr_q, rlfsr_d;
   logic [31:0]           err_q, err_d, sum_q, sum_d;
   logic [OW-1:0]         outst_q, outst_d;
   logic                  en_q, en_d, wren_q, wren_d;
   logic                  issued_q, issued_d, cmpd_q, cmpd_d;
   logic                  seen_q, seen_d, stop_q, stop_d;
   logic                  acc, wacc, rv;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            m,
      input logic [ADDR_WIDTH-1:0] a,
      input logic [31:0]           l
   );
      logic [31:0] a32, v;
      pattern = '0;
      a32     = 32'(a);
      for (int i = 0; i < LANES; i++) begin
         unique case (m)
            2'd0:    v = 32'h1;
            2'd1:    v = a32 + 32'(i);
            2'd2:    v = ~(a32 + 32'(i));
            default: v = i[0] ? ~l : l;
         endcase
         pattern[i*32 +: 32] = v;
      end
   endfunction

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      base_d   = base_q;
      last_d   = last_q;
      addr_d   = addr_q;
      cmp_d    = cmp_q;
      first_d  = first_q;
      wlfsr_d  = wlfsr_q;
      rlfsr_d  = rlfsr_q;
      err_d    = err_q;
      sum_d    = sum_q;
      outst_d  = outst_q;
      en_d     = en_q;
      wren_d   = wren_q;
      issued_d = issued_q;
      cmpd_d   = cmpd_q;
      seen_d   = seen_q;
      stop_d   = stop_q;
      acc      = en_q & app_rdy;
      wacc     = wren_q & app_wdf_rdy;
      rv       = app_rd_data_valid && (state_q == READ) && !cmpd_q;
      unique case (state_q)
         IDLE: begin
            if (w_start && w_calib_done) begin
               state_d = WRITE;
               mode_d  = w_mode;
               base_d  = w_base_addr;
               last_d  = (w_last_addr < w_base_addr) ? w_base_addr : w_last_addr;
               addr_d  = w_base_addr;
               wlfsr_d = 32'h1;
               en_d    = 1'b1;
               wren_d  = 1'b1;
               err_d   = '0;
               sum_d   = '0;
               first_d = '0;
               seen_d  = 1'b0;
               stop_d  = 1'b0;
            end
         end
         WRITE: begin
            if (acc) en_d = 1'b0;
            if (wacc) wren_d = 1'b0;
            if (!en_d && !wren_d && w_calib_done) state_d = WWAIT;
         end
         WWAIT: begin
            if (w_calib_done) begin
               if (addr_q == last_q) begin
                  state_d = RINIT;
               end else begin
                  addr_d  = addr_q + STEP;
                  wlfsr_d = lfsr_step(wlfsr_q);
                  en_d    = 1'b1;
                  wren_d  = 1'b1;
                  state_d = WRITE;
               end
            end
         end
         RINIT: begin
            if (w_calib_done) begin
               addr_d   = base_q;
               cmp_d    = base_q;
               rlfsr_d  = 32'h1;
               outst_d  = '0;
               issued_d = 1'b0;
               cmpd_d   = 1'b0;
               state_d  = READ;
            end
         end
         READ: begin
            if (acc) begin
               if (addr_q == last_q) issued_d = 1'b1;
               else addr_d = addr_q + STEP;
            end
            outst_d = outst_q + OW'(acc) - OW'(rv);
            if (rv) begin
               sum_d   = sum_q + app_rd_data[31:0];
               rlfsr_d = lfsr_step(rlfsr_q);
               if (cmp_q == last_q) cmpd_d = 1'b1;
               else cmp_d = cmp_q + STEP;
               if (app_rd_data != pattern(mode_q, cmp_q, rlfsr_q)) begin
                  if (err_q != '1) err_d = err_q + 32'd1;
                  if (!seen_q) first_d = cmp_q;
                  seen_d = 1'b1;
                  stop_d = stop_q | STOP_EN;
               end
            end
            // a request already on the bus is held until accepted
            if (en_q && !acc) en_d = 1'b1;
            else en_d = w_calib_done && !issued_d && !stop_d && (outst_d < MAX_OUT);
            if (w_calib_done && (cmpd_q || (stop_q && !en_q && outst_q == '0)))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q  <= IDLE;
         mode_q   <= '0;
         base_q   <= '0;
         last_q   <= '0;
         addr_q   <= '0;
         cmp_q    <= '0;
         first_q  <= '0;
         wlfsr_q  <= 32'h1;
         rlfsr_q  <= 32'h1;
         err_q    <= '0;
         sum_q    <= '0;
         outst_q  <= '0;
         en_q     <= 1'b0;
         wren_q   <= 1'b0;
         issued_q <= 1'b0;
         cmpd_q   <= 1'b0;
         seen_q   <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         base_q   <= base_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         cmp_q    <= cmp_d;
         first_q  <= first_d;
         wlfsr_q  <= wlfsr_d;
         rlfsr_q  <= rlfsr_d;
         err_q    <= err_d;
         sum_q    <= sum_d;
         outst_q  <= outst_d;
         en_q     <= en_d;
         wren_q   <= wren_d;
         issued_q <= issued_d;
         cmpd_q   <= cmpd_d;
         seen_q   <= seen_d;
         stop_q   <= stop_d;
      end
   end

   assign app_addr         = addr_q;
   assign app_cmd          = (state_q == READ) ? 3'b001 : 3'b000;
   assign app_en           = en_q;
   assign app_wdf_data     = wren_q ? pattern(mode_q, addr_q, wlfsr_q) : '0;
   assign app_wdf_wren     = wren_q;
   assign app_wdf_end      = wren_q;
   assign app_wdf_mask     = '0;
   assign r_busy           = (state_q != IDLE);
   assign r_done           = (state_q == DONE);
   assign r_err_cnt        = err_q;
   assign r_first_err_addr = first_q;
   assign r_sum            = sum_q;
   assign r_state          = state_q;

endmodule

// File: tb/tb_m_dram_bist.sv
// tb_m_dram_bist: random-handshake MIG memory model around m_dram_bist,
// results checked against a pattern/range reference computed in the bench.
module tb_m_dram_bist;

   localparam int AW  = 29;
   localparam int DW  = 128;
   localparam int MW  = 16;
   localparam int MAX = 16;

   logic          clk = 1'b0;
   logic          rst_n, calib, start;
   logic [1:0]    mode;
   logic [AW-1:0] base, last;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en, app_wdf_wren, app_wdf_end;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_rdy = 1'b0, app_wdf_rdy = 1'b0;
   logic [DW-1:0] app_rd_data = '0;
   logic          app_rd_data_valid = 1'b0;
   logic          r_busy, r_done;
   logic [31:0]   r_err_cnt, r_sum;
   logic [AW-1:0] r_first_err_addr;
   logic [2:0]    r_state;

   always #5 clk = ~clk;

   m_dram_bist dut (
      .w_clk(clk), .w_rst_n(rst_n), .w_calib_done(calib), .w_start(start),
      .w_mode(mode), .w_base_addr(base), .w_last_addr(last),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .r_busy(r_busy), .r_done(r_done), .r_err_cnt(r_err_cnt),
      .r_first_err_addr(r_first_err_addr), .r_sum(r_sum), .r_state(r_state)
   );

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // memory / MIG model state
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] wcmd_q[$];
   logic [DW-1:0] wdat_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int            rd_due_q[$];
   int  cyc = 0, rdy_pct = 100, wrdy_pct = 100, lat = 4, last_due = 0;
   int  n_wr, n_rd, n_ret, outst, max_outst, viol_full, viol_calib, done_pulses;
   bit  corrupt_en = 0;
   logic [AW-1:0] bad0 = 29'h10, bad1 = 29'h28;
   logic en_prev = 1'b0, calib_prev = 1'b0;

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int due;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            wcmd_q.delete(); wdat_q.delete();
            rd_addr_q.delete(); rd_due_q.delete();
            outst = 0; last_due = 0;
            app_rd_data_valid = 1'b0;
         end else begin
            if (outst >= MAX && app_en) viol_full++;
            if (!calib_prev && app_en && !en_prev) viol_calib++;
            if (r_done) done_pulses++;
            app_rdy     = ($urandom_range(99) < rdy_pct);
            app_wdf_rdy = ($urandom_range(99) < wrdy_pct);
            app_rd_data_valid = 1'b0;
            if (rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
               a = rd_addr_q.pop_front();
               void'(rd_due_q.pop_front());
               d = mem.exists(a) ? mem[a] : '0;
               if (corrupt_en && (a == bad0 || a == bad1)) d[0] = ~d[0];
               app_rd_data = d;
               app_rd_data_valid = 1'b1;
               n_ret++; outst--;
            end
            if (app_en && app_rdy) begin
               if (app_cmd == 3'b000) begin
                  wcmd_q.push_back(app_addr);
               end else begin
                  due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                  rd_addr_q.push_back(app_addr);
                  rd_due_q.push_back(due);
                  last_due = due;
                  n_rd++; outst++;
                  if (outst > max_outst) max_outst = outst;
               end
            end
            if (app_wdf_wren && app_wdf_rdy) wdat_q.push_back(app_wdf_data);
            while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
               mem[wcmd_q.pop_front()] = wdat_q.pop_front();
               n_wr++;
            end
         end
         en_prev    = app_en;
         calib_prev = calib;
      end
   end

   function automatic logic [31:0] ref_next(input logic [31:0] l);
      return {l[30:0], ^(l & 32'h8020_0003)};
   endfunction

   function automatic logic [DW-1:0] ref_beat(input logic [1:0] m, input logic [AW-1:0] a,
                                              input logic [31:0] lf);
      logic [DW-1:0] r;
      logic [31:0]   b32, w;
      r   = '0;
      b32 = {3'b000, a};
      for (int i = 0; i < DW / 32; i++) begin
         if (m == 2'd0) w = 32'd1;
         else if (m == 2'd1) w = b32 + i;
         else if (m == 2'd2) w = ~(b32 + i);
         else w = (i % 2 == 1) ? ~lf : lf;
         r[i*32 +: 32] = w;
      end
      return r;
   endfunction

   task automatic run_bist(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input int rp, input int wp, input int lt, input bit corrupt,
                           input bit drop, input string tag);
      int nb, nexp, errs, mem_bad;
      bit found, dropped;
      logic [31:0] lf, sum, lane0;
      logic [AW-1:0] a, first;
      logic [DW-1:0] exp_beat;
      mem.delete();
      n_wr = 0; n_rd = 0; n_ret = 0; max_outst = 0;
      viol_full = 0; viol_calib = 0; done_pulses = 0;
      rdy_pct = rp; wrdy_pct = wp; lat = lt; corrupt_en = corrupt;
      dropped = 0;
      @(posedge clk); #2;
      mode = m; base = b; last = l; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int c = 0; c < 20000 && done_pulses == 0; c++) begin
         @(posedge clk); #2;
         if (drop && !dropped && r_state == 3'd4 && n_ret >= 2) begin
            calib = 1'b0; dropped = 1;
            repeat (20) @(posedge clk);
            #2 calib = 1'b1;
         end
      end
      repeat (3) @(posedge clk);
      #2;
      nb = (l < b) ? 1 : int'((l - b) / 8) + 1;
`ifdef DRAM_BIST_STOP_ON_ERR_EN
      nexp = corrupt ? n_ret : nb;
`else
      nexp = nb;
`endif
      lf = 32'h1; sum = 0; errs = 0; found = 0; first = '0; mem_bad = 0;
      for (int k = 0; k < nb; k++) begin
         a = b + AW'(k * 8);
         exp_beat = ref_beat(m, a, lf);
         if (!mem.exists(a) || mem[a] !== exp_beat) mem_bad++;
         if (k < nexp) begin
            lane0 = exp_beat[31:0];
            if (corrupt && (a == bad0 || a == bad1)) begin
               lane0 ^= 32'd1; errs++;
               if (!found) first = a;
               found = 1;
            end
            sum += lane0;
         end
         lf = ref_next(lf);
      end
      check({tag, "_done_pulses"}, done_pulses, 1);
      check({tag, "_busy_after"}, r_busy, 0);
      check({tag, "_state_after"}, r_state, 0);
      check({tag, "_writes"}, n_wr, nb);
      check({tag, "_mem_beats"}, mem.num(), nb);
      check({tag, "_mem_data"}, mem_bad, 0);
      check({tag, "_reads_ret"}, n_ret, nexp);
      check({tag, "_drained"}, n_rd, n_ret);
      check({tag, "_sum"}, r_sum, sum);
      check({tag, "_err_cnt"}, r_err_cnt, errs);
      check({tag, "_first_err"}, r_first_err_addr, first);
      check({tag, "_outst_le_max"}, (max_outst <= MAX), 1);
      check({tag, "_en_when_full"}, viol_full, 0);
      check({tag, "_en_while_nocal"}, viol_calib, 0);
      if (done_pulses == 0) begin
         rst_n = 1'b0;
         @(posedge clk); #2 rst_n = 1'b1;
      end
   endtask

   initial begin
      logic [AW-1:0] rb;
      int rn;
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] rb;
      int rn;
      rst_n = 1'b0; calib = 1'b0; start = 1'b0;
      mode = '0; base = '0; last = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_app_en", app_en, 0);
      check("rst_wren", app_wdf_wren, 0);
      check("rst_state", r_state, 0);
      check("rst_busy", r_busy, 0);
      check("rst_err_cnt", r_err_cnt, 0);
      rst_n = 1'b1; calib = 1'b1;
      repeat (2) @(posedge clk);

      run_bist(2'd0, 29'h0, 29'h38, 100, 100, 5, 0, 0, "m0");
      run_bist(2'd1, 29'h0, 29'h38, 50, 50, 3, 0, 0, "m1");
      run_bist(2'd1, 29'h0, 29'h38, 30, 100, 3, 0, 0, "m1_wfirst");
      run_bist(2'd3, 29'h0, 29'h38, 100, 100, 6, 1, 0, "m3_err");
      run_bist(2'd2, 29'h100, 29'h80, 70, 70, 4, 0, 0, "inv_single");
      run_bist(2'd1, 29'h0, 29'h1F8, 100, 100, 40, 0, 0, "lat40");
      check("lat40_peak", max_outst, MAX);

      // async reset while a write is stalled
      rdy_pct = 0; wrdy_pct = 0;
      @(posedge clk); #2;
      mode = 2'd1; base = '0; last = 29'h38; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("midwr_state", r_state, 1);
      rst_n = 1'b0;
      #1;
      check("midwr_rst_en", app_en, 0);
      check("midwr_rst_wren", app_wdf_wren, 0);
      check("midwr_rst_busy", r_busy, 0);
      check("midwr_rst_state", r_state, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      run_bist(2'd1, 29'h0, 29'h38, 80, 80, 4, 0, 0, "post_rst");

      // start is ignored without calibration
      calib = 1'b0;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("nocal_state", r_state, 0);
      check("nocal_busy", r_busy, 0);
      calib = 1'b1;

      run_bist(2'd3, 29'h40, 29'h138, 80, 80, 6, 0, 1, "calib_drop");

      for (int r = 0; r < 6; r++) begin
         rb = AW'($urandom_range(255, 0)) * 29'd8;
         rn = $urandom_range(24, 1);
         run_bist(2'($urandom_range(3, 0)), rb, rb + AW'((rn - 1) * 8),
                  $urandom_range(100, 40), $urandom_range(100, 40),
                  $urandom_range(12, 2), 0, 0, $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
